// File: rtl/uart_pkg.sv
// Shared types and limits for the configurable UART transmitter and its FIFO.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int MIN_DIV  = 2;
  localparam int MIN_BITS = 5;
  localparam int MAX_BITS = 9;

  // XOR of the low nbits bits of data; bits at or above nbits do not contribute.
  function automatic logic calc_parity(input logic [MAX_BITS-1:0] data,
                                       input logic [3:0]          nbits);
    logic p;
    p = 1'b0;
    for (int i = 0; i < MAX_BITS; i++) begin
      p = p ^ (data[i] & (4'(i) < nbits));
    end
    return p;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; blocked push on full, blocked pop on empty.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      level_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (level_r == (AW+1)'(DEPTH));
  assign empty     = (level_r == {(AW+1){1'b0}});
  assign level     = level_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Storage array write port; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   level_r <= level_r + (AW+1)'(1);
        2'b01:   level_r <= level_r - (AW+1)'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with per-frame latched configuration and a queued front end,
// so consecutive frames leave back-to-back with no idle gap.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16,
  parameter int DATA_W     = 9
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic [3:0]                    cfg_data_bits,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  input  logic [DATA_W-1:0]             tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam logic [DIV_W-1:0] MIN_DIV_V  = DIV_W'(MIN_DIV);
  localparam logic [3:0]       MIN_BITS_V = 4'(MIN_BITS);
  localparam logic [3:0]       MAX_BITS_V = 4'(MAX_BITS);

  tx_state_t           state_r;
  logic [DATA_W-1:0]   shreg_r;
  logic [DIV_W-1:0]    div_l_r;
  logic [DIV_W-1:0]    cnt_r;
  logic [3:0]          nbits_l_r;
  logic [3:0]          bit_idx_r;
  logic                par_en_r;
  logic                par_bit_r;
  logic                stop2_l_r;
  logic                stop_cnt_r;
  logic                tx_r;

  logic [DATA_W-1:0]   fifo_rdata_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic [DIV_W-1:0]    div_eff_s;
  logic [3:0]          nbits_eff_s;
  logic                bit_end_s;
  logic                last_stop_s;
  logic                pop_s;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_valid),
    .wdata (tx_data),
    .pop   (pop_s),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .level (fifo_level)
  );

  assign tx_ready = !fifo_full_s;
  assign busy     = (state_r != IDLE) || !fifo_empty_s;
  assign tx       = tx_r;

  // Clamp live config and decide when the current bit ends and the next word is taken.
  always_comb begin
    div_eff_s = (cfg_div < MIN_DIV_V) ? MIN_DIV_V : cfg_div;
    if (cfg_data_bits < MIN_BITS_V) begin
      nbits_eff_s = MIN_BITS_V;
    end else if (cfg_data_bits > MAX_BITS_V) begin
      nbits_eff_s = MAX_BITS_V;
    end else begin
      nbits_eff_s = cfg_data_bits;
    end
    bit_end_s   = (cnt_r == {DIV_W{1'b0}});
    last_stop_s = (state_r == STOP) && bit_end_s && !(stop2_l_r && !stop_cnt_r);
    pop_s       = !fifo_empty_s && ((state_r == IDLE) || last_stop_s);
  end

  // Frame sequencer: every bit holds tx for div_l cycles, counted down to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      shreg_r    <= {DATA_W{1'b0}};
      div_l_r    <= MIN_DIV_V;
      cnt_r      <= {DIV_W{1'b0}};
      nbits_l_r  <= MIN_BITS_V;
      bit_idx_r  <= 4'd0;
      par_en_r   <= 1'b0;
      par_bit_r  <= 1'b0;
      stop2_l_r  <= 1'b0;
      stop_cnt_r <= 1'b0;
      tx_r       <= 1'b1;
    end else if (pop_s) begin
      state_r    <= START;
      tx_r       <= 1'b0;
      cnt_r      <= div_eff_s - DIV_W'(1);
      div_l_r    <= div_eff_s;
      nbits_l_r  <= nbits_eff_s;
      par_en_r   <= (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
      par_bit_r  <= calc_parity(MAX_BITS'(fifo_rdata_s), nbits_eff_s) ^ (cfg_parity == PAR_ODD);
      stop2_l_r  <= cfg_stop2;
      shreg_r    <= fifo_rdata_s;
      bit_idx_r  <= 4'd0;
      stop_cnt_r <= 1'b0;
    end else if (state_r == IDLE) begin
      tx_r <= 1'b1;
    end else if (!bit_end_s) begin
      cnt_r <= cnt_r - DIV_W'(1);
    end else begin
      cnt_r <= div_l_r - DIV_W'(1);
      case (state_r)
        START: begin
          state_r   <= DATA;
          tx_r      <= shreg_r[0];
          shreg_r   <= {1'b0, shreg_r[DATA_W-1:1]};
          bit_idx_r <= 4'd1;
        end
        DATA: begin
          if (bit_idx_r == nbits_l_r) begin
            if (par_en_r) begin
              state_r <= PARITY;
              tx_r    <= par_bit_r;
            end else begin
              state_r    <= STOP;
              tx_r       <= 1'b1;
              stop_cnt_r <= 1'b0;
            end
          end else begin
            tx_r      <= shreg_r[0];
            shreg_r   <= {1'b0, shreg_r[DATA_W-1:1]};
            bit_idx_r <= bit_idx_r + 4'd1;
          end
        end
        PARITY: begin
          state_r    <= STOP;
          tx_r       <= 1'b1;
          stop_cnt_r <= 1'b0;
        end
        STOP: begin
          if (!last_stop_s) begin
            stop_cnt_r <= 1'b1;
          end else begin
            state_r <= IDLE;
            tx_r    <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          tx_r    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: a line monitor checks every bit's level and
// duration against frames queued by the stimulus.
`timescale 1ns/1ps
module tb_uart_tx_cfg;

  typedef struct {
    int          div;
    int          len;
    logic [12:0] bits;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] cfg_div = 16'd4;
  logic [3:0]  cfg_data_bits = 4'd8;
  logic [1:0]  cfg_parity = 2'd0;
  logic        cfg_stop2 = 1'b0;
  logic [8:0]  tx_data = 9'd0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic        tx;
  logic        busy;
  logic [3:0]  fifo_level;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  frame_t exp_q[$];
  int     start_q[$];
  bit     mon_active = 1'b0;

  uart_tx_cfg dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_div       (cfg_div),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_stop2     (cfg_stop2),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx            (tx),
    .busy          (busy),
    .fifo_level    (fifo_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference frame: start, nb data bits LSB first, optional parity, 1 or 2 stop bits.
  function automatic frame_t mk(input logic [8:0] d, input int nb, input int par,
                                input bit s2, input int div);
    frame_t f;
    logic   p;
    int     n;
    f.div  = div;
    f.bits = {13{1'b1}};
    f.bits[0] = 1'b0;
    p = 1'b0;
    for (int i = 0; i < nb; i++) begin
      f.bits[1+i] = d[i];
      p = p ^ d[i];
    end
    n = 1 + nb;
    if (par == 1) begin
      f.bits[n] = p;
      n++;
    end else if (par == 2) begin
      f.bits[n] = ~p;
      n++;
    end
    n = n + (s2 ? 2 : 1);
    f.len = n;
    return f;
  endfunction

  // Line monitor: one comparison per bit, counting cycles at the expected level.
  initial begin
    frame_t cur;
    int bit_i, cyc_i, match_cnt, frame_no;
    bit skip_low;
    frame_no = 0;
    skip_low = 1'b0;
    bit_i = 0; cyc_i = 0; match_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_active = 1'b0;
        skip_low   = 1'b0;
      end else begin
        if (skip_low) begin
          if (tx === 1'b1) skip_low = 1'b0;
        end else if (!mon_active && tx === 1'b0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_start", tx, 1);
            skip_low = 1'b1;
          end else begin
            cur = exp_q.pop_front();
            mon_active = 1'b1;
            bit_i = 0; cyc_i = 0; match_cnt = 0;
            start_q.push_back(cyc);
          end
        end
        if (mon_active) begin
          if (tx === cur.bits[bit_i]) match_cnt++;
          cyc_i++;
          if (cyc_i == cur.div) begin
            check($sformatf("frame%0d_bit%0d_cycles", frame_no, bit_i), match_cnt, cur.div);
            bit_i++; cyc_i = 0; match_cnt = 0;
            if (bit_i == cur.len) begin
              mon_active = 1'b0;
              frame_no++;
            end
          end
        end
      end
    end
  end

  task automatic set_cfg(input int div, input int nb, input int par, input bit s2);
    cfg_div       = 16'(div);
    cfg_data_bits = 4'(nb);
    cfg_parity    = 2'(par);
    cfg_stop2     = s2;
  endtask

  task automatic push_word(input logic [8:0] d, input frame_t f);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    exp_q.push_back(f);
  endtask

  // From an idle DUT: accept, start bit one edge later, busy high for exactly len cycles.
  task automatic timed_frame(input string tag, input logic [8:0] d, input frame_t f, input int len);
    int k;
    check({tag, "_idle"}, busy, 0);
    push_word(d, f);
    check({tag, "_level"}, fifo_level, 1);
    @(posedge clk); #1;
    check({tag, "_start"}, tx, 0);
    k = 0;
    while (busy === 1'b1 && k < 5000) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_len"}, k, len);
  endtask

  task automatic drain(input string tag, input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || mon_active || busy !== 1'b0) && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_pending_frames"}, exp_q.size(), 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx", tx, 1);
    check("rst_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_level", fifo_level, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // 8N1, div 4, 0xA5
    set_cfg(4, 8, 0, 1'b0);
    timed_frame("8n1", 9'h0A5, mk(9'h0A5, 8, 0, 1'b0, 4), 40);
    drain("8n1", 100);

    // 7E2, div 3, 0x41
    set_cfg(3, 7, 1, 1'b1);
    timed_frame("7e2", 9'h041, mk(9'h041, 7, 1, 1'b1, 3), 33);
    drain("7e2", 100);

    // 8O1 with all-zero data: parity bit 1
    set_cfg(4, 8, 2, 1'b0);
    timed_frame("8o1", 9'h000, mk(9'h000, 8, 2, 1'b0, 4), 44);
    drain("8o1", 100);

    // 5E1: upper bits (bit 5 = 0) must not leak into the frame
    set_cfg(4, 5, 1, 1'b0);
    timed_frame("5e1", 9'h1DF, mk(9'h1DF, 5, 1, 1'b0, 4), 32);
    drain("5e1", 100);

    // Clamping: div 1 -> 2, 15 bits -> 9, parity code 3 -> none
    set_cfg(1, 15, 3, 1'b0);
    timed_frame("clamp_hi", 9'h155, mk(9'h155, 9, 0, 1'b0, 2), 22);
    drain("clamp_hi", 100);
    set_cfg(0, 2, 0, 1'b0);
    timed_frame("clamp_lo", 9'h00A, mk(9'h00A, 5, 0, 1'b0, 2), 14);
    drain("clamp_lo", 100);

    // Fill: 10 back-to-back requests at div 100, nine accepted
    set_cfg(100, 8, 0, 1'b0);
    start_q.delete();
    for (int i = 0; i < 10; i++) begin
      check($sformatf("fill_ready%0d", i), tx_ready, (i < 9));
      tx_data  = 9'(8'h30 + i);
      tx_valid = 1'b1;
      @(posedge clk); #1;
      if (i < 9) exp_q.push_back(mk(9'(8'h30 + i), 8, 0, 1'b0, 100));
    end
    tx_valid = 1'b0;
    check("fill_level", fifo_level, 8);
    check("fill_ready_low", tx_ready, 0);
    drain("fill", 9300);
    check("fill_frames", start_q.size(), 9);
    for (int i = 1; i < start_q.size(); i++) begin
      check($sformatf("fill_gap%0d", i), start_q[i] - start_q[i-1], 1000);
    end

    // Config change mid-frame applies only to the next frame
    set_cfg(4, 8, 0, 1'b0);
    start_q.delete();
    push_word(9'h0C3, mk(9'h0C3, 8, 0, 1'b0, 4));
    push_word(9'h03C, mk(9'h03C, 8, 0, 1'b1, 8));
    repeat (10) @(posedge clk);
    #1;
    set_cfg(8, 8, 0, 1'b1);
    drain("cfgchg", 300);
    check("cfgchg_frames", start_q.size(), 2);
    if (start_q.size() == 2) check("cfgchg_gap", start_q[1] - start_q[0], 40);

    // Asynchronous reset during a data bit
    set_cfg(4, 8, 0, 1'b0);
    push_word(9'h000, mk(9'h000, 8, 0, 1'b0, 4));
    push_word(9'h03C, mk(9'h03C, 8, 0, 1'b0, 4));
    push_word(9'h03C, mk(9'h03C, 8, 0, 1'b0, 4));
    repeat (8) @(posedge clk);
    #1;
    check("prerst_tx", tx, 0);
    check("prerst_level", fifo_level, 2);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("arst_tx", tx, 1);
    check("arst_level", fifo_level, 0);
    check("arst_ready", tx_ready, 1);
    check("arst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    timed_frame("post_rst", 9'h05A, mk(9'h05A, 8, 0, 1'b0, 4), 40);
    drain("post_rst", 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
- Runtime-configurable UART transmitter: 5–9 data bits, none/even/odd parity, 1 or 2 stop bits, and a run-time baud divisor.
- Includes a synchronous transmit FIFO, so the host can queue bytes and frames go out back-to-back.
- Replaces the fixed 8N1 transmitter on the bridge's host-facing link; the JTAG response path pushes bytes into it.

Parameters:
- FIFO_DEPTH, 8, number of FIFO entries; must be a power of two, at least 2.
- DIV_W, 16, width of the baud divisor input.
- DATA_W, 9, width of tx_data; fixed maximum number of data bits.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cfg_div  in  DIV_W  clock cycles per bit; values below 2 are treated as 2
- cfg_data_bits  in  4  data bits per frame, 5..9; values below 5 are used as 5, above 9 as 9
- cfg_parity  in  2  parity_e: 0 none, 1 even, 2 odd, 3 treated as none
- cfg_stop2  in  1  1 = two stop bits, 0 = one stop bit
- tx_data  in  DATA_W  word to send; the low cfg_data_bits bits are used
- tx_valid  in  1  write request
- tx_ready  out  1  high when the FIFO is not full
- tx  out  1  serial line; idles high
- busy  out  1  high when a frame is in progress or the FIFO is not empty
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of entries in the FIFO

Behaviour:
- Reset values: tx=1, tx_ready=1, busy=0, fifo_level=0, FSM in IDLE, FIFO empty. All are registered except tx_ready and busy, which are decoded from registered state.
- Accept rule: a word is accepted on a rising edge where tx_valid && tx_ready. When the FIFO is full, tx_valid is ignored and the word is dropped; the host must hold tx_valid.
- Latency: if the accept is on edge N, the FSM pops the word and drives tx=0 (start bit) on edge N+1. This applies when the FIFO was empty and the FSM was in IDLE.
- Configuration sampling: all cfg_* inputs are latched at the pop edge. The latched values apply for the whole frame; changes mid-frame affect only the next frame.
- Bit timing: every bit (start, data, parity, each stop bit) lasts exactly div_l clock cycles. The bit counter reloads at the first cycle of each bit. There is no drift and no extra idle cycle between bits.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If the FIFO is not empty, pop it, latch the configuration, go to START.
  - START: tx=0 for one bit, then DATA.
  - DATA: send bits LSB first, index 0..nbits-1. After the last bit, go to PARITY if parity is enabled, otherwise STOP.
  - PARITY: even mode sends the XOR of the nbits data bits; odd mode sends its inverse. Then STOP.
  - STOP: tx=1 for 1 or 2 bits. At the end, if the FIFO is not empty, pop it and go directly to START on the same edge (zero idle gap). Otherwise go to IDLE.
- Frame length: (1 + nbits + p + s) × div_l cycles, where p = parity bit (0/1) and s = stop bits (1/2).
- FIFO:
  - A simultaneous push and pop in one cycle is allowed; fifo_level is unchanged.
  - A push to a full FIFO is blocked, because tx_ready=0.
  - Pointers wrap modulo FIFO_DEPTH.
  - Capacity as seen by the host is FIFO_DEPTH words plus the word being shifted out.
- Reset mid-frame: tx returns high immediately (asynchronous). The FIFO empties and the frame is aborted; there is no completion.

Decomposition:
- Package uart_pkg holds:
  - typedef enum parity_e {PAR_NONE, PAR_EVEN, PAR_ODD}
  - typedef enum tx_state_t {IDLE, START, DATA, PARITY, STOP}
  - localparams MIN_DIV=2, MIN_BITS=5, MAX_BITS=9
- Sub-module sync_fifo (parameters WIDTH, DEPTH; ports push/pop/full/empty/level), reusable for the RX path.
- The FSM, bit counter and parity logic stay in uart_tx_cfg.

Test Plan:
- cfg_div=4, 8 data bits, no parity, 1 stop bit, send 0xA5 -> tx is 0 for 4 cycles, then 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles. The frame is 40 cycles long, and busy falls on the edge after the stop bit.
- 7 data bits, even parity, 2 stop bits, cfg_div=3, send 0x41 -> data bits 1,0,0,0,0,0,1, parity 0, two stop bits. The frame is 33 cycles long.
- 8 data bits, odd parity, send 0x00 -> parity bit 1. With 5 data bits, even parity, send 0x1F -> data bits 11111, parity 1, and bits above index 4 are ignored.
- cfg_div=100, push 10 words continuously -> 9 words are accepted, tx_ready drops, fifo_level=8. All words then go out back-to-back with no idle cycle between a stop bit and the next start bit.
- Change cfg_div 4→8 and cfg_stop2 0→1 during a frame's data bits -> the current frame keeps 4 cycles per bit and 1 stop bit. The next frame uses 8 cycles per bit and 2 stop bits.
- Assert rst in the middle of a data bit -> tx=1, fifo_level=0 and tx_ready=1 asynchronously. After release, a new push starts a clean frame one edge after the accept.
